// File: rtl/viterbi_decoder.sv
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) convolutional
//   code. A whole code frame is latched on start. The decoder then runs one
//   add-compare-select step per clock, traces back through the stored
//   decisions, and presents the decoded frame together with its path metric.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       asynchronous, active-high reset
//   start_i       latch code_in_i and begin decoding (ignored while busy_o=1)
//   code_in_i     code word; first symbol in the top two bits
//   busy_o        high from the start-accept edge until dec_valid_o rises
//   dec_valid_o   one-cycle pulse when dec_data_o/dec_metric_o update
//   dec_data_o    decoded bits; first-decoded bit at the MSB
//   dec_metric_o  Hamming distance of the chosen path
//
// Configuration
//   VITERBI_ZERO_TAIL_EN  when defined, traceback always starts from state 00
//                         (frames end in a zero-tail flush). Otherwise it
//                         starts from the lowest-index minimum-metric state.
//
// States
//   S_IDLE  | waiting for start_i; outputs hold the last result
//   S_ACS   | one add-compare-select step per clock, first symbol first
//   S_TRACE | walk the survivor decisions from the last step back to step 0
//   S_DONE  | publish decoded bits and metric, pulse dec_valid_o

module viterbi_decoder #(
    parameter int FRAME_LEN = 6,
    parameter int METRIC_W  = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [2*FRAME_LEN-1:0] code_in_i,
    output logic                   busy_o,
    output logic                   dec_valid_o,
    output logic [FRAME_LEN-1:0]   dec_data_o,
    output logic [METRIC_W-1:0]    dec_metric_o
);

    localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(FRAME_LEN - 1);
    // Non-zero start states begin half-scale so they lose to state 00
    // without risking saturation over a full frame.
    localparam logic [METRIC_W-1:0] PM_INIT = {1'b1, {(METRIC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACS, S_TRACE, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [2*FRAME_LEN-1:0]          code_q, code_d;
    logic [SW-1:0]                   step_q, step_d;
    logic [3:0][METRIC_W-1:0]        pm_q, pm_d;
    logic [FRAME_LEN-1:0][3:0]       surv_q, surv_d;
    logic [1:0]                      tb_q, tb_d;
    logic [FRAME_LEN-1:0]            buf_q, buf_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;
    logic [FRAME_LEN-1:0]            data_q, data_d;
    logic [METRIC_W-1:0]             metric_q, metric_d;

    logic [1:0]                      rx_sym;
    logic [3:0][METRIC_W-1:0]        pm_new;
    logic [3:0]                      dec_bits;
    logic [1:0]                      start_sel;
    logic [1:0]                      cur_s;

    function automatic logic [METRIC_W-1:0] add_sat(input logic [METRIC_W-1:0] a,
                                                    input logic [1:0]          b);
        logic [METRIC_W:0] s;
        s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
        return s[METRIC_W] ? '1 : s[METRIC_W-1:0];
    endfunction

    // Hamming distance between the received symbol and the symbol the encoder
    // would emit leaving predecessor p with input b.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                 input logic       b,
                                                 input logic [1:0] p);
        logic [1:0] exp_sym;
        logic [1:0] diff;
        exp_sym = {b ^ p[1] ^ p[0], b ^ p[0]};
        diff    = rx ^ exp_sym;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // Returns {decision, new metric} for next state ns = {b, s1}. The two
    // predecessors are {s1, 0} and {s1, 1}; a tie keeps the s0=0 path.
    function automatic logic [METRIC_W:0] acs(input logic [1:0]               ns,
                                              input logic [3:0][METRIC_W-1:0] pm,
                                              input logic [1:0]               rx);
        logic [1:0]          p0;
        logic [1:0]          p1;
        logic [METRIC_W-1:0] m0;
        logic [METRIC_W-1:0] m1;
        p0 = {ns[0], 1'b0};
        p1 = {ns[0], 1'b1};
        m0 = add_sat(pm[p0], branch_metric(rx, ns[1], p0));
        m1 = add_sat(pm[p1], branch_metric(rx, ns[1], p1));
        return (m1 < m0) ? {1'b1, m1} : {1'b0, m0};
    endfunction

    assign rx_sym = code_q[2*FRAME_LEN-1 -: 2];

    for (genvar g = 0; g < 4; g++) begin : g_acs
        assign {dec_bits[g], pm_new[g]} = acs(2'(g), pm_q, rx_sym);
    end

`ifdef VITERBI_ZERO_TAIL_EN
    assign start_sel = 2'b00;
`else
    logic [METRIC_W-1:0] best_m;
    always_comb begin
        start_sel = 2'd0;
        best_m    = pm_q[0];
        if (pm_q[1] < best_m) begin
            start_sel = 2'd1;
            best_m    = pm_q[1];
        end
        if (pm_q[2] < best_m) begin
            start_sel = 2'd2;
            best_m    = pm_q[2];
        end
        if (pm_q[3] < best_m) begin
            start_sel = 2'd3;
            best_m    = pm_q[3];
        end
    end
`endif

    // Metrics are frozen during traceback, so the start state can be derived
    // from pm_q on the first trace step instead of being registered.
    assign cur_s = (step_q == LAST_STEP) ? start_sel : tb_q;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        step_d   = step_q;
        pm_d     = pm_q;
        surv_d   = surv_q;
        tb_d     = tb_q;
        buf_d    = buf_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        metric_d = metric_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    code_d  = code_in_i;
                    step_d  = '0;
                    pm_d[0] = '0;
                    pm_d[1] = PM_INIT;
                    pm_d[2] = PM_INIT;
                    pm_d[3] = PM_INIT;
                    busy_d  = 1'b1;
                    state_d = S_ACS;
                end
            end
            S_ACS: begin
                pm_d           = pm_new;
                surv_d[step_q] = dec_bits;
                code_d         = code_q << 2;
                if (step_q == LAST_STEP) begin
                    state_d = S_TRACE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_TRACE: begin
                buf_d[LAST_STEP - step_q] = cur_s[1];
                tb_d = {cur_s[0], surv_q[step_q][cur_s]};
                if (step_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            S_DONE: begin
                data_d   = buf_q;
                metric_d = pm_q[start_sel];
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            step_q   <= '0;
            pm_q     <= '0;
            surv_q   <= '0;
            tb_q     <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            metric_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            step_q   <= step_d;
            pm_q     <= pm_d;
            surv_q   <= surv_d;
            tb_q     <= tb_d;
            buf_q    <= buf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            metric_q <= metric_d;
        end
    end

    assign busy_o       = busy_q;
    assign dec_valid_o  = valid_q;
    assign dec_data_o   = data_q;
    assign dec_metric_o = metric_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder
//   Directed-vector bench for viterbi_decoder. Stimulus pushes the expected
//   {data, metric} into a scoreboard queue; a monitor pops and compares on
//   every dec_valid pulse. Expected values are hand-derived from the trellis.

module tb_viterbi_decoder;

    localparam int F = 6;
    localparam int M = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2*F-1:0] code_in;
    logic           busy;
    logic           dec_valid;
    logic [F-1:0]   dec_data;
    logic [M-1:0]   dec_metric;

    typedef struct packed {
        logic [F-1:0] data;
        logic [M-1:0] metric;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;
    int   bc;

    viterbi_decoder #(.FRAME_LEN(F), .METRIC_W(M)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .code_in_i    (code_in),
        .busy_o       (busy),
        .dec_valid_o  (dec_valid),
        .dec_data_o   (dec_data),
        .dec_metric_o (dec_metric)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && dec_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got data %0h metric %0h expected no output",
                         dec_data, dec_metric);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dec_data", 32'(dec_data), 32'(e.data));
                check("dec_metric", 32'(dec_metric), 32'(e.metric));
            end
        end
    end

    // Drives start for one edge and queues the expected result.
    task automatic start_frame(input logic [2*F-1:0] code, input logic [F-1:0] d,
                               input logic [M-1:0] m);
        exp_t e;
        e.data   = d;
        e.metric = m;
        sb.push_back(e);
        start   = 1'b1;
        code_in = code;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    // Starts a frame and measures edges to dec_valid and cycles with busy high.
    task automatic run_timed(input logic [2*F-1:0] code, input logic [F-1:0] d,
                             input logic [M-1:0] m, output int l, output int b);
        bit found;
        found = 1'b0;
        start_frame(code, d, m);
        b = busy ? 1 : 0;
        l = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (dec_valid) begin
                l = i;
                found = 1'b1;
                break;
            end
            if (busy) b++;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: got no dec_valid expected one within 40 edges");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        code_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(dec_valid), 0);
        check("rst_data", 32'(dec_data), 0);
        check("rst_metric", 32'(dec_metric), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame: bits 0,1,1,1,0,0
        run_timed(12'h367, 6'h1C, 5'd0, lat, bc);
        check("t1_latency", 32'(lat), 13);
        drain("t1");
        repeat (4) @(posedge clk);
        #1;
        check("hold_data", 32'(dec_data), 32'h1C);
        check("hold_metric", 32'(dec_metric), 0);
        check("hold_valid", 32'(dec_valid), 0);

        // One corrupted bit in the fourth symbol
        start_frame(12'h377, 6'h1C, 5'd1);
        drain("t2");

        // All-zero frame, busy duration
        @(posedge clk);
        #1;
        run_timed(12'h000, 6'h00, 5'd0, lat, bc);
        check("t3_latency", 32'(lat), 13);
        check("t3_busy_cycles", 32'(bc), 13);
        drain("t3");

        // Start while busy is ignored; start in the dec_valid cycle is taken
        @(posedge clk);
        #1;
        start_frame(12'h367, 6'h1C, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        start   = 1'b1;
        code_in = 12'hFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t4_busy_held", 32'(busy), 1);
        for (int i = 0; i < 40; i++) begin
            if (dec_valid) break;
            @(posedge clk);
            #1;
        end
        check("t4_valid_seen", 32'(dec_valid), 1);
        start_frame(12'h377, 6'h1C, 5'd1);
        check("t4_b2b_busy", 32'(busy), 1);
        drain("t4");

        // Reset in the middle of a frame
        @(posedge clk);
        #1;
        start   = 1'b1;
        code_in = 12'h003;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(dec_valid), 0);
        check("t5_data", 32'(dec_data), 0);
        check("t5_metric", 32'(dec_metric), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start_frame(12'h367, 6'h1C, 5'd0);
        drain("t5");

        // Frame whose best path ends outside state 00 (last symbol 11 after zeros)
        @(posedge clk);
        #1;
`ifdef VITERBI_ZERO_TAIL_EN
        start_frame(12'h003, 6'h00, 5'd2);
`else
        start_frame(12'h003, 6'h01, 5'd0);
`endif
        drain("t6");
        @(posedge clk);
        #1;
        start_frame(12'h367, 6'h1C, 5'd0);
        drain("t6b");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
